// File: rtl/pipeline_sequencer.sv
// Central 5-stage pipeline sequencer: run / single-step / halt control,
// load-use stall and taken-branch flush generation, saturating stall counter.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  output logic             pc_ena,
  output logic             ifid_ena,
  output logic             stage_ena,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam int         DW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP_WAIT, S_STEP_EXEC, S_RUN, S_DRAIN, S_HALTED
  } state_t;

  state_t           state_q, state_d;
  logic             step_mode_q, step_mode_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic hazard;
  logic is_halt;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  // A halt in ID never stalls; it is handled by the drain path instead.
  always_comb begin
    is_halt = (id_opcode == OP_HALT);
    hazard  = ex_memread && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt))) && !is_halt;
  end

  // State register, latched step mode, drain counter and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      step_mode_q   <= 1'b0;
      drain_q       <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      step_mode_q   <= step_mode_d;
      drain_q       <= drain_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Next-state and per-stage enable/flush generation.
  always_comb begin
    state_d       = state_q;
    step_mode_d   = step_mode_q;
    drain_d       = drain_q;
    stall_count_d = stall_count_q;
    pc_ena        = 1'b0;
    ifid_ena      = 1'b0;
    stage_ena     = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // start wins over a coincident step; step is simply not looked at here
        if (start) begin
          step_mode_d = step_mode;
          state_d     = step_mode ? S_STEP_WAIT : S_RUN;
        end
      end

      S_STEP_WAIT: begin
        if (step) state_d = S_STEP_EXEC;
      end

      S_RUN, S_STEP_EXEC: begin
        pc_ena    = 1'b1;
        ifid_ena  = 1'b1;
        stage_ena = 1'b1;
        if (state_q == S_STEP_EXEC) state_d = S_STEP_WAIT;
        if (mem_branch_taken) begin
          // PC takes the branch target; everything younger is squashed
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (hazard) begin
          pc_ena     = 1'b0;
          ifid_ena   = 1'b0;
          idex_flush = 1'b1;
          if (stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
        end else if (is_halt) begin
          pc_ena     = 1'b0;
          ifid_flush = 1'b1;
          state_d    = S_DRAIN;
          drain_d    = DRAIN_LOAD;
        end
      end

      S_DRAIN: begin
        ifid_ena   = 1'b1;
        ifid_flush = 1'b1;
        stage_ena  = 1'b1;
        if (mem_branch_taken) begin
          // an older branch overrides the halt: resume fetching at the target
          pc_ena      = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          state_d     = step_mode_q ? S_STEP_WAIT : S_RUN;
          drain_d     = '0;
        end else if (drain_q == '0) begin
          state_d = S_HALTED;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      S_HALTED: ;

      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    running     = (state_q == S_RUN) || (state_q == S_STEP_EXEC) || (state_q == S_DRAIN);
    halted      = (state_q == S_HALTED);
    stall_count = stall_count_q;
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer. Inputs change on the falling edge,
// outputs are checked 1 time unit later. Output vector bit order:
// {pc_ena, ifid_ena, stage_ena, ifid_flush, idex_flush, exmem_flush, running, halted}
module tb_pipeline_sequencer;

  logic        clk, rst, start, step_mode, step;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, mem_branch_taken;
  logic        pc_ena, ifid_ena, stage_ena, ifid_flush, idex_flush, exmem_flush;
  logic        running, halted;
  logic [15:0] stall_count;
  logic [7:0]  outs;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_sequencer #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .pc_ena(pc_ena), .ifid_ena(ifid_ena), .stage_ena(stage_ena),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .running(running), .halted(halted), .stall_count(stall_count)
  );

  assign outs = {pc_ena, ifid_ena, stage_ena, ifid_flush, idex_flush, exmem_flush,
                 running, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] O_OFF   = 8'b0000_0000;
  localparam logic [7:0] O_RUN   = 8'b1110_0010;
  localparam logic [7:0] O_STALL = 8'b0010_1010;
  localparam logic [7:0] O_BR    = 8'b1111_1110;
  localparam logic [7:0] O_DRAIN = 8'b0111_0010;
  localparam logic [7:0] O_HALT  = 8'b0000_0001;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // check outputs for the current inputs, then advance through one rising edge
  task automatic cyc(input string tag, input logic [7:0] exp);
    #1 chk(tag, {24'd0, outs}, {24'd0, exp});
    @(negedge clk);
  endtask

  task automatic clr();
    start = 0; step_mode = 0; step = 0; id_opcode = 6'h00; id_rs = 5'd1; id_rt = 5'd2;
    id_uses_rt = 0; ex_memread = 0; ex_rt = 5'd0; mem_branch_taken = 0;
  endtask

  task automatic do_reset();
    rst = 1; clr();
    #1 chk("reset_outs", {24'd0, outs}, 32'd0);
    chk("reset_cnt", {16'd0, stall_count}, 32'd0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1; clr();
    @(negedge clk);
    do_reset();

    // 1: free run, independent instructions
    start = 1; step_mode = 0; cyc("idle_start", O_OFF);
    clr();
    for (int i = 0; i < 3; i++) cyc("run_alu", O_RUN);
    chk("cnt_after_alu", {16'd0, stall_count}, 32'd0);

    // 2: load-use on rs, then ex_rt=0, then rt with/without id_uses_rt
    ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5; cyc("stall_rs", O_STALL);
    clr(); cyc("after_stall", O_RUN);
    chk("cnt_one", {16'd0, stall_count}, 32'd1);
    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0; cyc("no_stall_r0", O_RUN);
    ex_memread = 1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 0;
    cyc("no_stall_rt_unused", O_RUN);
    id_uses_rt = 1; cyc("stall_rt", O_STALL);
    clr(); cyc("run_again", O_RUN);
    chk("cnt_two", {16'd0, stall_count}, 32'd2);

    // 3: branch beats load-use
    ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5; mem_branch_taken = 1; cyc("br_over_stall", O_BR);
    clr(); cyc("run_after_br", O_RUN);
    chk("cnt_br", {16'd0, stall_count}, 32'd2);

    // 4: halt in RUN, three drain cycles, then HALTED until reset
    id_opcode = 6'h3F; cyc("halt_seen", O_DRAIN);
    clr();
    for (int i = 0; i < 3; i++) cyc("drain", O_DRAIN);
    start = 1; step = 1; cyc("halted", O_HALT);
    clr(); cyc("halted_hold", O_HALT);
    chk("cnt_kept", {16'd0, stall_count}, 32'd2);
    do_reset();

    // 5: step mode
    step = 1; cyc("step_in_idle", O_OFF);
    clr(); cyc("still_idle", O_OFF);
    start = 1; step_mode = 1; step = 1; cyc("start_step_same", O_OFF);
    clr(); cyc("step_wait", O_OFF);
    cyc("step_wait2", O_OFF);
    step = 1; cyc("step_pulse1", O_OFF);
    clr(); cyc("step_exec1", O_RUN);
    cyc("step_wait3", O_OFF);
    cyc("step_wait4", O_OFF);
    step = 1; cyc("step_pulse2", O_OFF);
    clr(); cyc("step_exec2", O_RUN);
    cyc("step_wait5", O_OFF);
    // halt in a step, branch during drain returns to STEP_WAIT
    step = 1; cyc("step_pulse3", O_OFF);
    clr(); id_opcode = 6'h3F; cyc("step_halt", O_DRAIN);
    clr(); cyc("step_drain", O_DRAIN);
    mem_branch_taken = 1; cyc("step_drain_br", O_BR);
    clr(); cyc("back_step_wait", O_OFF);
    do_reset();

    // 6: branch during drain in free run, then reset during drain
    start = 1; cyc("idle_start2", O_OFF);
    clr(); cyc("run2", O_RUN);
    id_opcode = 6'h3F; cyc("halt2", O_DRAIN);
    clr(); cyc("drain2", O_DRAIN);
    cyc("drain2b", O_DRAIN);
    mem_branch_taken = 1; cyc("drain_br", O_BR);
    clr(); cyc("resume_run", O_RUN);
    cyc("resume_run2", O_RUN);
    id_opcode = 6'h3F; cyc("halt3", O_DRAIN);
    clr(); cyc("drain3", O_DRAIN);
    rst = 1;
    #1 chk("rst_in_drain", {24'd0, outs}, 32'd0);
    @(negedge clk);
    rst = 0; cyc("idle_after_rst", O_OFF);
    cyc("idle_after_rst2", O_OFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
